// File: rtl/ycell_edge_drv.sv
// ycell_edge_drv: clocked "red cell" boundary row driving the yellow-cell array top row.
// Latency: arr_in 1 cycle after accept; out_valid SYNC+1 cycles after the last pair returns.
// Backpressure: in_ready low unless idle with the array empty; the array is held full until out_ready.
//
// Ports:
//   clk, resetn           system clock, asynchronous active-low reset
//   in_valid/in_ready     launch handshake, in_data bit i -> pair i (1: 2'b10, 0: 2'b01)
//   out_valid/out_ready   result handshake; out_data, out_err, out_tmo held while out_valid
//   arr_empty             to cell uempty inputs, high only while in reset
//   arr_in                registered dual-rail drive, pair i = arr_in[2i+1:2i]
//   arr_back              asynchronous dual-rail return from the cells, synchronized here
module ycell_edge_drv #(
   parameter int W    = 8,
   parameter int SYNC = 2,
   parameter int TMO  = 1023
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_data,
   output logic [W-1:0]   out_err,
   output logic           out_tmo,
   output logic [W-1:0]   arr_empty,
   output logic [2*W-1:0] arr_in,
   input  logic [2*W-1:0] arr_back
);

   // Fewer than two synchronizer stages is never safe for these asynchronous returns.
   localparam int            NS     = (SYNC < 2) ? 2 : SYNC;
   localparam int            CW     = (TMO < 2) ? 1 : $clog2(TMO + 1);
   localparam logic [CW-1:0] TMO_LD = CW'(TMO);
   localparam bit            TMO_EN = (TMO != 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_HOLD,
      S_RELEASE
   } state_t;

   state_t         state_q;
   logic [2*W-1:0] sync_q [NS];
   logic [NS-1:0]  warm_q;
   logic [CW-1:0]  cnt_q;
   logic [CW-1:0]  cnt_d;
   logic [2*W-1:0] arr_in_q;
   logic           in_ready_q;
   logic           out_valid_q;
   logic           out_tmo_q;
   logic [W-1:0]   out_data_q;
   logic [W-1:0]   out_err_q;

   logic [2*W-1:0] sb;
   logic [2*W-1:0] drive_word;
   logic [W-1:0]   pair_full;
   logic [W-1:0]   pair_v1;
   logic [W-1:0]   pair_bad;
   logic           all_full;
   logic           all_empty;
   logic           tmo_hit;

   // Synchronizer chain on every returning wire. warm_q tracks how many stages
   // hold post-reset samples, so an array still full after reset is not
   // mistaken for empty while the chain refills with zeros.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int s = 0; s < NS; s++) begin
            sync_q[s] <= '0;
         end
         warm_q <= '0;
      end else begin
         sync_q[0] <= arr_back;
         for (int s = 1; s < NS; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         warm_q <= {warm_q[NS-2:0], 1'b1};
      end
   end

   assign sb = sync_q[NS-1];

   always_comb begin
      pair_full  = '0;
      pair_v1    = '0;
      pair_bad   = '0;
      drive_word = '0;
      for (int i = 0; i < W; i++) begin
         pair_full[i]      = sb[2*i+1] | sb[2*i];
         pair_v1[i]        = sb[2*i+1] & ~sb[2*i];
         pair_bad[i]       = sb[2*i+1] & sb[2*i];
         drive_word[2*i+1] = in_data[i];
         drive_word[2*i]   = ~in_data[i];
      end
   end

   assign all_full  = &pair_full;
   assign all_empty = ~|pair_full;
   // Expiry is the cycle the counter would reach zero; TMO=0 never expires.
   assign tmo_hit   = TMO_EN && (cnt_q == CW'(1));
   assign cnt_d     = cnt_q - CW'(1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         arr_in_q    <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_tmo_q   <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  arr_in_q   <= drive_word;
                  cnt_q      <= TMO_LD;
                  out_tmo_q  <= 1'b0;
                  in_ready_q <= 1'b0;
                  state_q    <= S_DRIVE;
               end else begin
                  in_ready_q <= warm_q[NS-1] & all_empty;
               end
            end
            S_DRIVE: begin
               // Completion is tested first so it wins over a same-cycle expiry.
               if (all_full) begin
                  out_data_q  <= pair_v1;
                  out_err_q   <= pair_bad;
                  out_tmo_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= S_HOLD;
               end else if (tmo_hit) begin
                  out_data_q  <= pair_v1;
                  out_err_q   <= ~pair_full | pair_bad;
                  out_tmo_q   <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= S_HOLD;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_HOLD: begin
               // Array stays full and the counter frozen until the result is taken.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  arr_in_q    <= '0;
                  cnt_q       <= TMO_LD;
                  state_q     <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (all_empty) begin
                  in_ready_q <= warm_q[NS-1];
                  state_q    <= S_IDLE;
               end else if (tmo_hit) begin
                  // Sticky flag; IDLE keeps in_ready low until the array drains.
                  out_tmo_q <= 1'b1;
                  state_q   <= S_IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign arr_in    = arr_in_q;
   assign arr_empty = {W{~resetn}};
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;
   assign out_tmo   = out_tmo_q;

endmodule

// File: doc/ycell_edge_drv.md
Name: ycell_edge_drv

Overview:
- Synchronous-to-asynchronous boundary stage ("red cell" row) that sits directly upstream of the yellow-cell array.
- Drives W vertical dual-rail inputs into the top row of the array and waits for each column's final result to return on the up-going pair.
- Captures that result word, hands it to the clocked system, then runs the return-to-empty phase before accepting the next word.
- Implements the four-phase empty/value/empty protocol the array expects on its boundary.

Parameters:
- W, 8, number of array columns driven and sampled.
- SYNC, 2, synchronizer flop stages on every returning wire (minimum 2).
- TMO, 1023, timeout in clk cycles for either wait phase; 0 disables the timeout.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  request to launch in_data.
- in_ready  output  1  block idle and array fully empty.
- in_data  input  W  bit i: 1 -> drive V1 (2'b10), 0 -> drive V0 (2'b01).
- out_valid  output  1  result word held.
- out_ready  input  1  consumer accepts result.
- out_data  output  W  bit i = 1 when returned pair i was V1.
- out_err  output  W  bit i = 1 when returned pair i was 2'b11 or timed out.
- out_tmo  output  1  the result was produced by a timeout.
- arr_empty  output  W  to the cells' uempty inputs; constant 0 while resetn=1, all 1 during reset.
- arr_in  output  2W  to the cells' uin; pair i = arr_in[2i+1:2i].
- arr_back  input  2W  from the cells' uout (asynchronous).

Behaviour:
- Reset values: arr_in=0, arr_empty=all 1, in_ready=0, out_valid=0, out_data=0, out_err=0, out_tmo=0. All synchronizers are cleared; the FSM goes to IDLE.
- Every arr_back bit passes through SYNC flops. All decisions use only synchronized values, called sb. A pair is non-empty when its OR is 1.
- arr_in is driven straight from registers so it is glitch-free. Both bits of a pair are never 1 at the same time.
- FSM states:
  - IDLE:
    - arr_in=0.
    - in_ready=1 only when every sb pair equals 00; otherwise 0.
    - On in_valid & in_ready: register the drive word, load the timeout counter and go to DRIVE. arr_in changes at the next edge.
  - DRIVE:
    - Hold arr_in.
    - When every sb pair is non-empty: latch out_data[i]=sb[2i+1] & ~sb[2i] and out_err[i]=&sb pair, set out_valid=1, go to HOLD.
    - If the counter expires first: latch out_data from the current sb, set out_err[i]=1 for each pair that is empty or 11, set out_tmo=1, out_valid=1, go to HOLD.
  - HOLD:
    - arr_in keeps its value (the array stays full until the result is consumed).
    - On out_valid & out_ready: clear out_valid, set arr_in=0, reload the counter, go to RELEASE.
  - RELEASE:
    - arr_in=0.
    - When every sb pair equals 00, go to IDLE.
    - On counter expiry: go to IDLE and set out_tmo=1, sticky until the next accepted in_valid. in_ready stays 0 until the array actually empties.
- Output stability: out_data, out_err and out_tmo stay stable while out_valid=1. They keep their last values after the handshake.
- Latency:
  - arr_in asserts 1 cycle after the accepting edge.
  - out_valid asserts SYNC+1 cycles after the last arr_back pair becomes non-empty.
  - in_ready reasserts SYNC+1 cycles after the last pair empties.
- Counter: decrements by 1 per cycle in DRIVE and RELEASE only. It is frozen in HOLD and expires on reaching 0.
- Simultaneous events: in DRIVE, if all pairs become non-empty and the counter reaches 0 in the same cycle, completion wins and out_tmo=0.
- Early return: a pair that returns non-empty before its input was driven (array misconfigured, or a stale value) is treated as complete data. in_ready gating prevents this in normal use.
- Reset mid-operation: on resetn low everything clears asynchronously.
  - arr_empty=1 forces the top cells to treat their column as isolated.
  - After release, the block waits in IDLE for the array to drain, with in_ready held 0.

Test Plan:
- W=4, in_data=4'b1010 with the array model echoing each pair after 5 ns: arr_in=8'b10011001. The same code returns on arr_back, giving out_data=4'b1010, out_err=0 and out_valid exactly SYNC+1 cycles after the last echo. After out_ready, arr_in=0 and in_ready returns once the echo clears.
- Pair 2 returns 2'b11: out_err=4'b0100, with the other bits correct.
- Pair 0 never returns, TMO=20: out_valid is asserted 20 cycles after entering DRIVE, with out_tmo=1 and out_err[0]=1.
- out_ready held low for 50 cycles: arr_in stays driven, the outputs stay stable, and the counter does not expire.
- resetn pulsed low during DRIVE: all outputs go to their reset values at once. in_ready stays 0 until the model clears arr_back.
- Completion and expiry forced into the same cycle: out_tmo=0 and the result is reported as complete.
